// File: rtl/operand_fetch_pkg.sv
// Shared 8051 datapath definitions for the operand-fetch stage: source codes, PSW bank bits,
// FSM encodings and operand address helpers.
package operand_fetch_pkg;

    localparam logic [2:0] SRC_ACC = 3'd0;
    localparam logic [2:0] SRC_IMM = 3'd1;
    localparam logic [2:0] SRC_DIR = 3'd2;
    localparam logic [2:0] SRC_REG = 3'd3;
    localparam logic [2:0] SRC_IND = 3'd4;

    localparam int unsigned PSW_RS1 = 4;
    localparam int unsigned PSW_RS0 = 3;

    typedef enum logic [3:0] {
        StIdle, StAIss, StACap, StAPiss, StAPcap,
        StBIss, StBCap, StBPiss, StBPcap, StOut
    } opf_state_e;

    typedef enum logic [2:0] {SeqIdle, SeqPIss, SeqPCap, SeqIss, SeqCap} seq_state_e;

    function automatic logic opf_src_illegal(input logic [2:0] src);
        return src > SRC_IND;
    endfunction

    // Undefined codes fall back to ACC when illegal-source trapping is off.
    function automatic logic [2:0] opf_norm_src(input logic [2:0] src);
        return (src > SRC_IND) ? SRC_ACC : src;
    endfunction

    function automatic logic opf_src_ram(input logic [2:0] src);
        return (src == SRC_DIR) || (src == SRC_REG) || (src == SRC_IND);
    endfunction

    function automatic logic [7:0] opf_first_addr(input logic [2:0] src, input logic [7:0] addr,
                                                  input logic [1:0] bank);
        case (src)
            SRC_REG: return {3'b000, bank, addr[2:0]};
            SRC_IND: return {3'b000, bank, 2'b00, addr[0]};
            default: return addr;
        endcase
    endfunction

endpackage

// File: rtl/iram_rd_seq.sv
// Internal-RAM read sequencer: a single data read, or a pointer read followed by a data read
// at the returned byte. Started by i_start, reports o_done in the data-capture cycle.
module iram_rd_seq
    import operand_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_ind,
    input  logic [7:0]        i_addr,
    input  logic [7:0]        i_rdata,
    output logic              o_ram_rd,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_done,
    output logic [7:0]        o_data
);

    seq_state_e r_state, w_state_d;
    logic [7:0] r_addr, w_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SeqIdle;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_d;
            r_addr  <= w_addr_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_addr_d  = r_addr;
        if (i_start) begin
            w_state_d = i_ind ? SeqPIss : SeqIss;
            w_addr_d  = i_addr;
        end else begin
            case (r_state)
                SeqPIss: w_state_d = SeqPCap;
                SeqPCap: begin
                    w_state_d = SeqIss;
                    w_addr_d  = i_rdata;
                end
                SeqIss:  w_state_d = SeqCap;
                default: w_state_d = SeqIdle;
            endcase
        end
    end

    assign o_ram_rd   = (r_state == SeqPIss) || (r_state == SeqIss);
    assign o_ram_addr = o_ram_rd ? ADDR_W'(r_addr) : '0;
    assign o_done     = (r_state == SeqCap);
    assign o_data     = i_rdata;

endmodule

// File: rtl/operand_fetch.sv
// 8051 operand-fetch stage: resolves operands A then B from ACC, IMM or internal RAM.
// Define OPF_ILLEGAL_SRC_EN to trap source codes 5-7 (pulse illegal, drop the instruction).
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [3:0]        dec_op,
    input  logic [2:0]        dec_bit,
    input  logic [2:0]        src_a,
    input  logic [2:0]        src_b,
    input  logic [7:0]        addr_a,
    input  logic [7:0]        addr_b,
    input  logic [7:0]        imm,
    input  logic [7:0]        acc_in,
    input  logic [7:0]        psw_in,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [7:0]        a_data,
    output logic [7:0]        b_data,
    output logic [3:0]        alu_op,
    output logic [2:0]        bit_location,
    output logic [7:0]        psw_out,
    output logic              illegal
);

    opf_state_e r_state, w_state_d;
    logic [2:0] w_src_a, w_src_b, r_src_b;
    logic [7:0] r_addr_b, r_psw, r_a, r_b;
    logic [3:0] r_op;
    logic [2:0] r_bit;
    logic       r_illegal;
    logic       w_illegal_src, w_accept, w_go;
    logic       w_seq_start, w_seq_ind, w_seq_done;
    logic [7:0] w_seq_addr, w_seq_data;

    assign w_src_a  = opf_norm_src(src_a);
    assign w_src_b  = opf_norm_src(src_b);
    assign w_accept = dec_valid && dec_ready;
    assign w_go     = w_accept && !w_illegal_src;

`ifdef OPF_ILLEGAL_SRC_EN
    assign w_illegal_src = opf_src_illegal(src_a) || opf_src_illegal(src_b);
`else
    assign w_illegal_src = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state;
        w_seq_start = 1'b0;
        w_seq_ind   = 1'b0;
        w_seq_addr  = '0;
        case (r_state)
            StIdle: begin
                if (w_go) begin
                    if (opf_src_ram(w_src_a)) begin
                        w_seq_start = 1'b1;
                        w_seq_ind   = (w_src_a == SRC_IND);
                        w_seq_addr  = opf_first_addr(w_src_a, addr_a, psw_in[PSW_RS1:PSW_RS0]);
                        w_state_d   = w_seq_ind ? StAPiss : StAIss;
                    end else if (opf_src_ram(w_src_b)) begin
                        w_seq_start = 1'b1;
                        w_seq_ind   = (w_src_b == SRC_IND);
                        w_seq_addr  = opf_first_addr(w_src_b, addr_b, psw_in[PSW_RS1:PSW_RS0]);
                        w_state_d   = w_seq_ind ? StBPiss : StBIss;
                    end else begin
                        w_state_d = StOut;
                    end
                end
            end
            StAPiss: w_state_d = StAPcap;
            StAPcap: w_state_d = StAIss;
            StAIss:  w_state_d = StACap;
            StACap: begin
                if (w_seq_done) begin
                    // Chain straight into operand B so its read issues the next cycle.
                    if (opf_src_ram(r_src_b)) begin
                        w_seq_start = 1'b1;
                        w_seq_ind   = (r_src_b == SRC_IND);
                        w_seq_addr  = opf_first_addr(r_src_b, r_addr_b, r_psw[PSW_RS1:PSW_RS0]);
                        w_state_d   = w_seq_ind ? StBPiss : StBIss;
                    end else begin
                        w_state_d = StOut;
                    end
                end
            end
            StBPiss: w_state_d = StBPcap;
            StBPcap: w_state_d = StBIss;
            StBIss:  w_state_d = StBCap;
            StBCap:  if (w_seq_done) w_state_d = StOut;
            StOut:   if (op_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_src_b   <= SRC_ACC;
            r_addr_b  <= '0;
            r_psw     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_bit     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_illegal <= w_accept && w_illegal_src;
            if (w_go) begin
                r_op     <= dec_op;
                r_bit    <= dec_bit;
                r_psw    <= psw_in;
                r_src_b  <= w_src_b;
                r_addr_b <= addr_b;
                // RAM-sourced operands are overwritten later in their capture state.
                r_a      <= (w_src_a == SRC_IMM) ? imm : acc_in;
                r_b      <= (w_src_b == SRC_IMM) ? imm : acc_in;
            end
            if (r_state == StACap && w_seq_done) r_a <= w_seq_data;
            if (r_state == StBCap && w_seq_done) r_b <= w_seq_data;
        end
    end

    iram_rd_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_seq_start),
        .i_ind      (w_seq_ind),
        .i_addr     (w_seq_addr),
        .i_rdata    (ram_rdata),
        .o_ram_rd   (ram_rd),
        .o_ram_addr (ram_addr),
        .o_done     (w_seq_done),
        .o_data     (w_seq_data)
    );

    assign dec_ready    = (r_state == StIdle);
    assign op_valid     = (r_state == StOut);
    assign a_data       = r_a;
    assign b_data       = r_b;
    assign alu_op       = r_op;
    assign bit_location = r_bit;
    assign psw_out      = r_psw;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: RAM model, per-cycle operand/timing model, directed cases.
module tb_operand_fetch;

    logic       clk;
    logic       rst_n;
    logic       dec_valid, dec_ready;
    logic [3:0] dec_op;
    logic [2:0] dec_bit, src_a, src_b;
    logic [7:0] addr_a, addr_b, imm, acc_in, psw_in;
    logic       ram_rd;
    logic [7:0] ram_addr, ram_rdata;
    logic       op_valid, op_ready;
    logic [7:0] a_data, b_data, psw_out;
    logic [3:0] alu_op;
    logic [2:0] bit_location;
    logic       illegal;

    operand_fetch #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_op       (dec_op),
        .dec_bit      (dec_bit),
        .src_a        (src_a),
        .src_b        (src_b),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .imm          (imm),
        .acc_in       (acc_in),
        .psw_in       (psw_in),
        .ram_rd       (ram_rd),
        .ram_addr     (ram_addr),
        .ram_rdata    (ram_rdata),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .a_data       (a_data),
        .b_data       (b_data),
        .alu_op       (alu_op),
        .bit_location (bit_location),
        .psw_out      (psw_out),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    logic       exp_active = 1'b0;
    int         exp_cyc = 0;
    int         exp_lat = 0;
    logic [7:0] exp_a, exp_b, exp_psw;
    logic [3:0] exp_op;
    logic [2:0] exp_bit;

    // RAM answers exactly one cycle after a strobe; junk otherwise.
    always @(posedge clk) ram_rdata <= ram_rd ? mem[ram_addr] : 8'($urandom);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] m_operand(input logic [2:0] src, input logic [7:0] addr,
                                             input logic [7:0] acc, input logic [7:0] im,
                                             input logic [7:0] ps);
        logic [7:0] rn;
        rn = 8'(ps[4:3]) * 8'd8;
        case (src)
            3'd1:    return im;
            3'd2:    return mem[addr];
            3'd3:    return mem[rn + 8'(addr[2:0])];
            3'd4:    return mem[mem[rn + 8'(addr[0])]];
            default: return acc;
        endcase
    endfunction

    function automatic int m_cost(input logic [2:0] src);
        if (src == 3'd2 || src == 3'd3) return 2;
        if (src == 3'd4) return 4;
        return 0;
    endfunction

    task automatic push_addrs(input logic [2:0] src, input logic [7:0] addr, input logic [7:0] ps);
        logic [7:0] rn;
        rn = 8'(ps[4:3]) * 8'd8;
        if (src == 3'd2) exp_q.push_back(addr);
        if (src == 3'd3) exp_q.push_back(rn + 8'(addr[2:0]));
        if (src == 3'd4) begin
            exp_q.push_back(rn + 8'(addr[0]));
            exp_q.push_back(mem[rn + 8'(addr[0])]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_active) begin
            exp_cyc++;
            if (exp_cyc < exp_lat) begin
                chk("early_valid", op_valid, 0);
                chk("busy_ready", dec_ready, 0);
            end else begin
                chk("op_valid", op_valid, 1);
                chk("out_ready", dec_ready, 0);
                chk("a_data", a_data, exp_a);
                chk("b_data", b_data, exp_b);
                chk("alu_op", alu_op, exp_op);
                chk("bit_location", bit_location, exp_bit);
                chk("psw_out", psw_out, exp_psw);
            end
            chk("illegal_quiet", illegal, 0);
            if (ram_rd) begin
                if (exp_q.size() == 0) chk("extra_ram_rd", ram_rd, 0);
                else chk("ram_addr", ram_addr, exp_q.pop_front());
            end
        end else begin
            chk("idle_no_rd", ram_rd, 0);
            chk("idle_no_valid", op_valid, 0);
        end
    end

    task automatic issue(input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] aa,
                         input logic [7:0] ab, input logic [7:0] im, input logic [7:0] ac,
                         input logic [7:0] ps, input logic [3:0] op, input logic [2:0] bl);
        @(negedge clk);
        chk("ready_before", dec_ready, 1);
        src_a = sa; src_b = sb; addr_a = aa; addr_b = ab; imm = im;
        acc_in = ac; psw_in = ps; dec_op = op; dec_bit = bl; dec_valid = 1'b1;
        exp_a = m_operand(sa, aa, ac, im, ps);
        exp_b = m_operand(sb, ab, ac, im, ps);
        exp_lat = 1 + m_cost(sa) + m_cost(sb);
        exp_op = op; exp_bit = bl; exp_psw = ps;
        exp_q.delete();
        push_addrs(sa, aa, ps);
        push_addrs(sb, ab, ps);
        @(posedge clk);
        #1;
        dec_valid = 1'b0;
        acc_in = ~ac; psw_in = ~ps; imm = ~im;
        exp_cyc = 0;
        exp_active = 1'b1;
    endtask

    task automatic run_instr(input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] aa,
                             input logic [7:0] ab, input logic [7:0] im, input logic [7:0] ac,
                             input logic [7:0] ps, input logic [3:0] op, input logic [2:0] bl,
                             input int hold, input logic [7:0] la, input logic [7:0] lb,
                             input int llat);
        int cnt;
        issue(sa, sb, aa, ab, im, ac, ps, op, bl);
        chk("model_a", exp_a, la);
        chk("model_b", exp_b, lb);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!op_valid && cnt < 40);
        if (!op_valid) begin
            chk("valid_timeout", op_valid, 1);
            exp_active = 1'b0;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        chk("latency", cnt, llat);
        chk("a_lit", a_data, la);
        chk("b_lit", b_data, lb);
        repeat (hold) @(negedge clk);
        op_ready = 1'b1;
        @(posedge clk);
        #1;
        op_ready = 1'b0;
        exp_active = 1'b0;
        chk("reads_done", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h15] = 8'h77; mem[8'h01] = 8'h40; mem[8'h40] = 8'hA5;
        mem[8'h30] = 8'h11; mem[8'h00] = 8'h31; mem[8'h31] = 8'h22;
        mem[8'h11] = 8'h50; mem[8'h50] = 8'h6B; mem[8'h10] = 8'h51;
        mem[8'h51] = 8'hC4; mem[8'h1A] = 8'h3E; mem[8'h7F] = 8'h81;

        dec_valid = 0; op_ready = 0; dec_op = 0; dec_bit = 0; src_a = 0; src_b = 0;
        addr_a = 0; addr_b = 0; imm = 0; acc_in = 0; psw_in = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dec_ready", dec_ready, 1);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_a", a_data, 0);
        chk("rst_b", b_data, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_bit", bit_location, 0);
        chk("rst_psw", psw_out, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;

        run_instr(3'd0, 3'd1, 8'h00, 8'h00, 8'h5A, 8'h3C, 8'h00, 4'd2, 3'd3, 0, 8'h3C, 8'h5A, 1);
        run_instr(3'd0, 3'd3, 8'h00, 8'h05, 8'h00, 8'h12, 8'h10, 4'd5, 3'd1, 0, 8'h12, 8'h77, 3);
        run_instr(3'd4, 3'd1, 8'h01, 8'h00, 8'h09, 8'h00, 8'h00, 4'd7, 3'd6, 1, 8'hA5, 8'h09, 5);
        run_instr(3'd2, 3'd4, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 4'd9, 3'd2, 3, 8'h11, 8'h22, 7);
        run_instr(3'd4, 3'd4, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h10, 4'd14, 3'd7, 0, 8'h6B, 8'hC4, 9);
        run_instr(3'd3, 3'd2, 8'hFA, 8'h7F, 8'h00, 8'h00, 8'h9A, 4'd1, 3'd4, 2, 8'h3E, 8'h81, 5);

`ifdef OPF_ILLEGAL_SRC_EN
        @(negedge clk);
        src_a = 3'd6; src_b = 3'd1; acc_in = 8'h4D; imm = 8'h2E; dec_valid = 1'b1;
        @(posedge clk);
        #1;
        dec_valid = 1'b0;
        @(negedge clk);
        chk("illegal_pulse", illegal, 1);
        chk("illegal_ready", dec_ready, 1);
        @(negedge clk);
        chk("illegal_one_cycle", illegal, 0);
`else
        run_instr(3'd6, 3'd1, 8'h00, 8'h00, 8'h2E, 8'h4D, 8'h08, 4'd3, 3'd0, 0, 8'h4D, 8'h2E, 1);
`endif

        // Abort in the middle of operand B's capture cycle.
        issue(3'd2, 3'd2, 8'h30, 8'h7F, 8'h00, 8'h00, 8'h00, 4'd6, 3'd5);
        repeat (3) @(posedge clk);
        #2;
        exp_active = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("abort_valid", op_valid, 0);
        chk("abort_rd", ram_rd, 0);
        chk("abort_ready", dec_ready, 1);
        chk("abort_a", a_data, 0);
        chk("abort_psw", psw_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_instr(3'd1, 3'd2, 8'h00, 8'h30, 8'hC3, 8'h00, 8'h18, 4'd11, 3'd3, 1, 8'hC3, 8'h11, 3);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
